// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the instruction/data memory arbiter.
//   arb_state_t : bus FSM states (idle, address phase, data phase)
//   arb_owner_t : which requester owns the outstanding bus transaction
//   bus_size_t  : transfer size encoding used on the request and bus sides
//   seg_t       : fixed-segment MMU region of a virtual address
//   seg_of()    : classifies a virtual address into its segment
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } arb_owner_t;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } bus_size_t;

   typedef enum logic [1:0] {
      SEG_KUSEG  = 2'd0,
      SEG_KSEG0  = 2'd1,
      SEG_KSEG1  = 2'd2,
      SEG_KSEG23 = 2'd3
   } seg_t;

   localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
   localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
   localparam logic [31:0] KSEG2_BASE = 32'hC000_0000;

   // Starvation counter width; holds any limit in 1..15.
   localparam int unsigned STREAK_W = 4;

   function automatic seg_t seg_of(input logic [31:0] vaddr);
      if (vaddr < KSEG0_BASE) begin
         return SEG_KUSEG;
      end else if (vaddr < KSEG1_BASE) begin
         return SEG_KSEG0;
      end else if (vaddr < KSEG2_BASE) begin
         return SEG_KSEG1;
      end else begin
         return SEG_KSEG23;
      end
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the instruction port, the data port and the downstream bus of the
// memory arbiter.
//   slave  : the arbiter's view (serves the fetch and load/store requesters,
//            drives the downstream bus request fields)
//   master : the surrounding system's view (pipeline requesters plus the
//            cache/AXI bridge answering on the bus)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;

   // instruction fetch port
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   // data (load/store) port
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   // downstream bus
   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_cached;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   modport slave (
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_cached,
      input  bus_addr_ok, bus_data_ok, bus_rdata
   );

   modport master (
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_cached,
      output bus_addr_ok, bus_data_ok, bus_rdata
   );

endinterface

// File: rtl/mem_arbiter_mmu.sv
// -----------------------------------------------------------------------------
// mem_arbiter_mmu
// Fixed-segment virtual-to-physical translation (purely combinational).
//   vaddr  in  32  virtual address
//   paddr  out 32  physical address
//   cached out 1   1 = cacheable region
// kseg0 and kseg1 both alias the low 512 MiB of physical memory; kseg1 is the
// uncached window. kuseg and kseg2/3 pass through unmapped and cacheable.
// -----------------------------------------------------------------------------
module mem_arbiter_mmu
   import mem_arbiter_pkg::*;
(
   input  logic [31:0] vaddr,
   output logic [31:0] paddr,
   output logic        cached
);

   always_comb begin
      paddr  = vaddr;
      cached = 1'b1;
      case (seg_of(vaddr))
         SEG_KSEG0: paddr = vaddr - KSEG0_BASE;
         SEG_KSEG1: begin
            paddr  = vaddr - KSEG1_BASE;
            cached = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one SRAM-like bus between instruction fetch and data load/store.
// At most one bus transaction is outstanding; the granted address is
// translated by the MMU and latched together with the transfer attributes.
//   clk, rst     : clock, asynchronous active-high reset
//   ifc (slave)  : inst_* / data_* requester ports and bus_* downstream port
// Parameter STARVE_LIMIT (1..15): consecutive contested data grants after which
// a waiting instruction request wins the next arbitration.
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave ifc
);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

   arb_state_t          state_reg,  state_next;
   arb_owner_t          owner_reg,  owner_next;
   logic [STREAK_W-1:0] streak_reg, streak_next;
   logic [31:0]         paddr_reg,  paddr_next;
   logic [31:0]         wdata_reg,  wdata_next;
   logic [1:0]          size_reg,   size_next;
   logic                wr_reg,     wr_next;
   logic                cached_reg, cached_next;

   logic                grant_inst;
   logic                grant_data;
   logic [31:0]         grant_vaddr;
   logic [31:0]         mmu_paddr;
   logic                mmu_cached;

   // Data normally wins; a starved instruction request wins once the
   // contested-data streak has reached the limit.
   assign grant_inst  = ifc.inst_req && (!ifc.data_req || (streak_reg == STREAK_MAX));
   assign grant_data  = ifc.data_req && !grant_inst;
   assign grant_vaddr = grant_inst ? ifc.inst_addr : ifc.data_addr;

   mem_arbiter_mmu u_mmu (
      .vaddr  (grant_vaddr),
      .paddr  (mmu_paddr),
      .cached (mmu_cached)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         owner_reg  <= OWN_NONE;
         streak_reg <= '0;
         paddr_reg  <= '0;
         wdata_reg  <= '0;
         size_reg   <= '0;
         wr_reg     <= 1'b0;
         cached_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         streak_reg <= streak_next;
         paddr_reg  <= paddr_next;
         wdata_reg  <= wdata_next;
         size_reg   <= size_next;
         wr_reg     <= wr_next;
         cached_reg <= cached_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      owner_next       = owner_reg;
      streak_next      = streak_reg;
      paddr_next       = paddr_reg;
      wdata_next       = wdata_reg;
      size_next        = size_reg;
      wr_next          = wr_reg;
      cached_next      = cached_reg;
      ifc.inst_addr_ok = 1'b0;
      ifc.inst_data_ok = 1'b0;
      ifc.inst_rdata   = '0;
      ifc.data_addr_ok = 1'b0;
      ifc.data_data_ok = 1'b0;
      ifc.data_rdata   = '0;

      case (state_reg)
         ST_IDLE: begin
            if (grant_inst || grant_data) begin
               state_next  = ST_ADDR;
               paddr_next  = mmu_paddr;
               cached_next = mmu_cached;
               if (grant_inst) begin
                  owner_next  = OWN_INST;
                  wr_next     = 1'b0;
                  size_next   = SIZE_WORD;
                  wdata_next  = '0;
                  streak_next = '0;
               end else begin
                  owner_next = OWN_DATA;
                  wr_next    = ifc.data_wr;
                  size_next  = ifc.data_size;
                  wdata_next = ifc.data_wdata;
                  // Only grants that made an instruction wait count as contested.
                  if (!ifc.inst_req) begin
                     streak_next = '0;
                  end else if (streak_reg != STREAK_MAX) begin
                     streak_next = streak_reg + 1'b1;
                  end
               end
            end
         end

         ST_ADDR: begin
            // Address acceptance is reported to the owner in the same cycle.
            if (ifc.bus_addr_ok) begin
               state_next       = ST_DATA;
               ifc.inst_addr_ok = (owner_reg == OWN_INST);
               ifc.data_addr_ok = (owner_reg == OWN_DATA);
            end
         end

         ST_DATA: begin
            // Read data passes straight through to the owner on completion.
            if (ifc.bus_data_ok) begin
               state_next = ST_IDLE;
               owner_next = OWN_NONE;
               if (owner_reg == OWN_INST) begin
                  ifc.inst_data_ok = 1'b1;
                  ifc.inst_rdata   = ifc.bus_rdata;
               end
               if (owner_reg == OWN_DATA) begin
                  ifc.data_data_ok = 1'b1;
                  ifc.data_rdata   = ifc.bus_rdata;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
            owner_next = OWN_NONE;
         end
      endcase
   end

   // Latched fields are driven continuously; only bus_req qualifies them.
   assign ifc.bus_req    = (state_reg == ST_ADDR);
   assign ifc.bus_wr     = wr_reg;
   assign ifc.bus_size   = size_reg;
   assign ifc.bus_addr   = paddr_reg;
   assign ifc.bus_wdata  = wdata_reg;
   assign ifc.bus_cached = cached_reg;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch port and the data (load/store) port.
- Translates each granted virtual address to a physical address through the fixed-segment MMU mapping.
- Tags each transaction cached or uncached, and keeps at most one bus transaction outstanding.
- Sits between the pipeline fetch/memory stages and the cache/AXI bridge.

Parameters:
STARVE_LIMIT, 4, consecutive contested data grants before a waiting instruction request is forced through (legal range 1..15).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
inst_req  in  1  instruction read request, held until inst_addr_ok
inst_addr  in  32  instruction virtual address
inst_addr_ok  out  1  instruction address accepted (pulse)
inst_data_ok  out  1  instruction read data valid (pulse)
inst_rdata  out  32  instruction read data
data_req  in  1  data request, held until data_addr_ok
data_wr  in  1  1=write, 0=read
data_size  in  2  0=byte, 1=half, 2=word
data_addr  in  32  data virtual address
data_wdata  in  32  write data
data_addr_ok  out  1  data address accepted (pulse)
data_data_ok  out  1  data read/write complete (pulse)
data_rdata  out  32  data read data
bus_req  out  1  downstream request
bus_wr  out  1  downstream write
bus_size  out  2  downstream size
bus_addr  out  32  physical address
bus_wdata  out  32  downstream write data
bus_cached  out  1  1=cacheable access
bus_addr_ok  in  1  downstream address accepted
bus_data_ok  in  1  downstream data phase done
bus_rdata  in  32  downstream read data

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values:
  - state=IDLE, owner=NONE, streak=0.
  - All bus_* outputs 0.
  - All *_ok outputs 0; inst_rdata and data_rdata 0.
- FSM has three states: IDLE, ADDR, DATA.
- IDLE:
  - Grant is evaluated combinationally.
  - If any request is present, next state is ADDR.
  - On grant, latch owner, paddr, cached, wr, size and wdata. An instruction grant latches wr=0, size=2.
- Grant rule:
  - Data has priority over instruction.
  - Exception: if inst_req=1, data_req=1 and streak==STARVE_LIMIT, the instruction wins.
- streak counter:
  - Increments on a data grant while inst_req=1, saturating at STARVE_LIMIT.
  - Clears on any instruction grant, or on a data grant with inst_req=0.
- ADDR:
  - bus_req=1 with the latched fields driven.
  - On bus_addr_ok=1: pulse the owner's *_addr_ok combinationally in that same cycle, drop bus_req next cycle, and go to DATA.
  - bus_addr_ok=0 holds the state indefinitely, with all fields stable.
- DATA:
  - bus_req=0.
  - On bus_data_ok=1: route bus_rdata to the owner's rdata and pulse the owner's data_ok in the same cycle (combinational pass-through); next state IDLE, owner=NONE.
  - The non-owner's ok outputs stay 0.
- Latency: a request sampled in IDLE at cycle n gives bus_req=1 at n+1. Minimum turnaround is 3 cycles with zero-wait downstream (IDLE, ADDR, DATA). The next grant is evaluated in the IDLE cycle that follows.
- Translation, applied to the address at grant:
  - vaddr < 0x8000_0000 (kuseg): paddr=vaddr, cached=1.
  - 0x8000_0000..0x9FFF_FFFF (kseg0): paddr=vaddr-0x8000_0000, cached=1.
  - 0xA000_0000..0xBFFF_FFFF (kseg1): paddr=vaddr-0xA000_0000, cached=0.
  - >= 0xC000_0000 (kseg2/3): paddr=vaddr, cached=1.
  - Segment boundaries are exact, e.g. 0x9FFF_FFFC is kseg0 and 0xA000_0000 is kseg1.
- Boundary conditions:
  - bus_data_ok in IDLE or ADDR is ignored, and bus_addr_ok in IDLE or DATA is ignored. Downstream guarantees data_ok comes at least one cycle after addr_ok.
  - A requester dropping req before addr_ok is a protocol violation; the arbiter still completes the latched transaction.
  - A request arriving during ADDR or DATA waits; there is no queueing beyond the request line.
  - rst mid-transaction: immediate return to reset values, no ok pulse is generated, and the transaction is abandoned. The downstream block is reset by the same rst.
- Widths: the address subtract is 32-bit and cannot underflow within the segment ranges.

Decomposition:
- Shared package (cpu_pkg additions):
  - arb_state_t enum {IDLE, ADDR, DATA}.
  - arb_owner_t enum {NONE, INST, DATA}.
  - Segment base constants KSEG0_BASE=0x8000_0000, KSEG1_BASE=0xA000_0000, KSEG2_BASE=0xC000_0000.
  - SIZE_BYTE/HALF/WORD constants.
- Sub-module: the existing mmu instantiated once on the muxed grant address. No second sub-module.

Test Plan:
- Data read 0xBFC0_0000 alone, zero-wait bus, bus_rdata=0x1234_5678:
  - bus_addr=0x1FC0_0000, bus_cached=0.
  - data_data_ok pulses 3 cycles after the request with data_rdata=0x1234_5678.
  - inst_* ok outputs stay 0.
- inst_req at 0x8000_0100 and data_req at 0x0040_0000, both asserted in the same cycle:
  - Data granted first (bus_addr=0x0040_0000, cached=1).
  - Instruction granted next (bus_addr=0x0000_0100, cached=1).
- STARVE_LIMIT=4, inst_req held and data_req continuously re-asserted: grant order is D,D,D,D,I,D,... and streak returns to 0 after the instruction grant.
- Data write size=1, wdata=0xBEEF, addr 0xC000_0010, with bus_addr_ok delayed 5 cycles:
  - bus_req, bus_wr=1, bus_size=1, bus_addr=0xC000_0010 held stable for 5 cycles.
  - data_addr_ok pulses in the same cycle as bus_addr_ok.
- Assert rst in DATA state, before bus_data_ok:
  - All outputs are 0 in the same cycle.
  - A later bus_data_ok produces no ok pulse.
  - After rst release, a new inst_req at 0x9FFF_FFFC maps to 0x1FFF_FFFC, cached=1.
